// File: rtl/music_seq_rom.sv
// music_seq_rom - tune sequencer between the play/restart buttons and the
// per-voice tone generators.
//
// A beat timer walks a synchronous tune ROM. Each ROM word holds VOICES
// fields of {tie, note}, with voice 0 in the LSBs. Each field gives one
// concurrent note, and every new note onset raises a one-cycle retrigger
// pulse for its voice. Note code 0 is a rest. If the voice-0 field is all
// ones, the word is an END marker.
//
// The tune image arrives as the packed parameter ROM_INIT, with word i at
// bits [i*WORD_W +: WORD_W]. The build scripts generate it from the tune
// hex file (Bach.hex), so the ROM stays constant and needs no load-time
// initialisation.
//
// Optional feature macro: MUSIC_SEQ_LOOP_EN
//   defined   : END at a non-zero address rewinds to word 0 and keeps playing;
//               END at word 0 still stops in DONE (an empty tune must not spin).
//   undefined : END always stops in DONE.
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   play       in   level: 1 = run, 0 = pause
//   restart    in   1-cycle pulse: rewind to word 0 (highest priority)
//   notes      out  VOICES*NOTE_W, voice v at [v*NOTE_W +: NOTE_W]; 0 while paused
//   retrig     out  per-voice 1-cycle onset pulse
//   beat_tick  out  1-cycle pulse when a new word is presented
//   addr       out  word address being played
//   playing    out  1 in FETCH/LOAD/PLAY while play=1
//   done       out  1 in DONE
module music_seq_rom #(
  parameter int VOICES   = 2,
  parameter int NOTE_W   = 7,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BEAT_DIV = 12_500_000,
  parameter logic [DEPTH*VOICES*(NOTE_W+1)-1:0] ROM_INIT = '0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     play,
  input  logic                     restart,
  output logic [VOICES*NOTE_W-1:0] notes,
  output logic [VOICES-1:0]        retrig,
  output logic                     beat_tick,
  output logic [ADDR_W-1:0]        addr,
  output logic                     playing,
  output logic                     done
);

  localparam int FIELD_W = NOTE_W + 1;
  localparam int WORD_W  = VOICES * FIELD_W;
  localparam int CNT_W   = $clog2(BEAT_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [CNT_W-1:0]         beatCnt_q, beatCnt_d;
  logic [VOICES*NOTE_W-1:0] notes_q, notes_d;
  logic [VOICES-1:0]        retrig_q, retrig_d;
  logic                     beatTick_q, beatTick_d;
  logic                     done_q, done_d;
  logic [WORD_W-1:0]        romData_q;

  logic [WORD_W-1:0]        romWords [DEPTH];
  logic [VOICES*NOTE_W-1:0] loadNotes;
  logic [VOICES-1:0]        loadRetrig;
  logic                     isEnd;
  logic                     running;

  // Constant ROM: slice the packed image into addressable words.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign romWords[i] = ROM_INIT[i*WORD_W +: WORD_W];
  end

  assign isEnd   = (romData_q[FIELD_W-1:0] == {FIELD_W{1'b1}});
  assign running = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);

  // A voice retriggers on any non-rest note unless it is tied to the
  // identical note already sounding.
  always_comb begin
    loadNotes  = '0;
    loadRetrig = '0;
    for (int v = 0; v < VOICES; v++) begin
      loadNotes[v*NOTE_W +: NOTE_W] = romData_q[v*FIELD_W +: NOTE_W];
      loadRetrig[v] = (romData_q[v*FIELD_W +: NOTE_W] != '0) &&
                      !(romData_q[v*FIELD_W + NOTE_W] &&
                        (romData_q[v*FIELD_W +: NOTE_W] == notes_q[v*NOTE_W +: NOTE_W]));
    end
  end

  // Next-state logic. Restart overrides everything. Otherwise play=0 in the
  // active states freezes the state, address and beat counter, so a resume
  // continues the beat with no retrigger.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beatCnt_d  = beatCnt_q;
    notes_d    = notes_q;
    retrig_d   = '0;
    beatTick_d = 1'b0;
    done_d     = done_q;
    if (restart) begin
      state_d   = play ? S_FETCH : S_IDLE;
      addr_d    = '0;
      beatCnt_d = '0;
      notes_d   = '0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (play) state_d = S_FETCH;
        S_FETCH: if (play) begin
          state_d   = S_LOAD;
          beatCnt_d = beatCnt_q + 1'b1;
        end
        S_LOAD: if (play) begin
          beatCnt_d = beatCnt_q + 1'b1;
          if (isEnd) begin
`ifdef MUSIC_SEQ_LOOP_EN
            if (addr_q != '0) begin
              state_d   = S_FETCH;
              addr_d    = '0;
              beatCnt_d = '0;
            end else begin
              state_d   = S_DONE;
              beatCnt_d = '0;
              notes_d   = '0;
              done_d    = 1'b1;
            end
`else
            state_d   = S_DONE;
            beatCnt_d = '0;
            notes_d   = '0;
            done_d    = 1'b1;
`endif
          end else begin
            state_d    = S_PLAY;
            notes_d    = loadNotes;
            retrig_d   = loadRetrig;
            beatTick_d = 1'b1;
          end
        end
        S_PLAY: if (play) begin
          if (beatCnt_q == CNT_LAST) begin
            state_d   = S_FETCH;
            beatCnt_d = '0;
            addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers. The ROM read happens while FETCH is active, so the
  // word is valid in LOAD, and the note outputs appear one cycle after that.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beatCnt_q  <= '0;
      notes_q    <= '0;
      retrig_q   <= '0;
      beatTick_q <= 1'b0;
      done_q     <= 1'b0;
      romData_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beatCnt_q  <= beatCnt_d;
      notes_q    <= notes_d;
      retrig_q   <= retrig_d;
      beatTick_q <= beatTick_d;
      done_q     <= done_d;
      if (state_q == S_FETCH) romData_q <= romWords[addr_q];
    end
  end

  // While paused, the notes are muted at the output only, so the held
  // notes come back unchanged on resume.
  assign notes     = (running && !play) ? '0 : notes_q;
  assign retrig    = retrig_q;
  assign beat_tick = beatTick_q;
  assign addr      = addr_q;
  assign playing   = running && play;
  assign done      = done_q;

endmodule
